// File: rtl/sample_framer.sv
// Serial-to-parallel sample framer with a one-entry valid/ready output stage.
// Frames completed while the output is blocked are dropped and counted.
module sample_framer #(
    parameter int unsigned FRAME_LEN  = 3,
    parameter int unsigned DROP_CNT_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic                  in_bit,
    input  logic                  in_sof,
    output logic                  frm_valid,
    input  logic                  frm_ready,
    output logic [FRAME_LEN-1:0]  frm_data,
    output logic [DROP_CNT_W-1:0] drop_cnt,
    output logic                  overflow,
    output logic                  misalign
);

    localparam int unsigned SLOT_W = (FRAME_LEN > 2) ? $clog2(FRAME_LEN) : 1;

    typedef enum logic {
        EMPTY   = 1'b0,
        PARTIAL = 1'b1
    } state_t;

    state_t                  state, state_n;
    logic [SLOT_W-1:0]       slot, slot_n;
    logic [FRAME_LEN-1:0]    assembly, assembly_n;
    logic [FRAME_LEN-1:0]    frame_c;
    logic                    complete_c;

    logic                    frm_valid_n;
    logic [FRAME_LEN-1:0]    frm_data_n;
    logic [DROP_CNT_W-1:0]   drop_cnt_n;
    logic                    overflow_n;
    logic                    misalign_n;

    // Next-state: assembly FSM and output register handshake
    always_comb begin
        state_n     = state;
        slot_n      = slot;
        assembly_n  = assembly;
        frame_c     = assembly;
        complete_c  = 1'b0;
        misalign_n  = misalign;
        frm_valid_n = frm_valid;
        frm_data_n  = frm_data;
        drop_cnt_n  = drop_cnt;
        overflow_n  = overflow;

        if (in_valid) begin
            case (state)
                EMPTY: begin
                    assembly_n = FRAME_LEN'(in_bit);
                    slot_n     = SLOT_W'(1);
                    state_n    = PARTIAL;
                end
                PARTIAL: begin
                    if (in_sof) begin
                        // Realign: the marked sample restarts the frame at slot 0
                        misalign_n = 1'b1;
                        assembly_n = FRAME_LEN'(in_bit);
                        slot_n     = SLOT_W'(1);
                    end else begin
                        for (int i = 0; i < int'(FRAME_LEN); i++) begin
                            if (slot == SLOT_W'(i)) frame_c[i] = in_bit;
                        end
                        assembly_n = frame_c;
                        if (slot == SLOT_W'(FRAME_LEN - 1)) begin
                            complete_c = 1'b1;
                            slot_n     = '0;
                            state_n    = EMPTY;
                        end else begin
                            slot_n = slot + SLOT_W'(1);
                        end
                    end
                end
                default: begin
                    state_n = EMPTY;
                    slot_n  = '0;
                end
            endcase
        end

        if (complete_c) begin
            if (!frm_valid || frm_ready) begin
                frm_valid_n = 1'b1;
                frm_data_n  = frame_c;
            end else begin
                overflow_n = 1'b1;
                if (drop_cnt != '1) drop_cnt_n = drop_cnt + DROP_CNT_W'(1);
            end
        end else if (frm_valid && frm_ready) begin
            frm_valid_n = 1'b0;
        end
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= EMPTY;
            slot      <= '0;
            assembly  <= '0;
            frm_valid <= 1'b0;
            frm_data  <= '0;
            drop_cnt  <= '0;
            overflow  <= 1'b0;
            misalign  <= 1'b0;
        end else begin
            state     <= state_n;
            slot      <= slot_n;
            assembly  <= assembly_n;
            frm_valid <= frm_valid_n;
            frm_data  <= frm_data_n;
            drop_cnt  <= drop_cnt_n;
            overflow  <= overflow_n;
            misalign  <= misalign_n;
        end
    end

endmodule
